inv_mix_columns: RTL and testbench

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

---
 rtl/aes_pkg.sv | 34 +++
 rtl/inv_mix_column.sv | 26 ++
 rtl/inv_mix_columns.sv | 123 ++++++++++++
 tb/tb_inv_mix_columns.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-MixColumns definitions: GF(2^8) constants, FSM state type
// and field arithmetic helpers.
package aes_pkg;

    localparam logic [7:0] GF_REDUCE = 8'h1b;

    localparam logic [7:0] INV_COEF_E = 8'h0e;
    localparam logic [7:0] INV_COEF_B = 8'h0b;
    localparam logic [7:0] INV_COEF_D = 8'h0d;
    localparam logic [7:0] INV_COEF_9 = 8'h09;

    typedef enum logic {
        IDLE,
        RUN
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

    // Shift-and-add multiply; the loop unrolls into a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] term;
        acc  = 8'h00;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ term;
            term = xtime(term);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column (row 0 in the top byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Each output row uses the coefficient row rotated right by its row index.
    assign col_out[31:24] = gf_mul(INV_COEF_E, a0) ^ gf_mul(INV_COEF_B, a1) ^
                            gf_mul(INV_COEF_D, a2) ^ gf_mul(INV_COEF_9, a3);
    assign col_out[23:16] = gf_mul(INV_COEF_9, a0) ^ gf_mul(INV_COEF_E, a1) ^
                            gf_mul(INV_COEF_B, a2) ^ gf_mul(INV_COEF_D, a3);
    assign col_out[15:8]  = gf_mul(INV_COEF_D, a0) ^ gf_mul(INV_COEF_9, a1) ^
                            gf_mul(INV_COEF_E, a2) ^ gf_mul(INV_COEF_B, a3);
    assign col_out[7:0]   = gf_mul(INV_COEF_B, a0) ^ gf_mul(INV_COEF_D, a1) ^
                            gf_mul(INV_COEF_9, a2) ^ gf_mul(INV_COEF_E, a3);

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a 128-bit state, column-serial by default.
// Define INV_MIX_ONE_CYCLE_EN to compute all four columns on the accept edge.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] state,
    output logic [127:0] state_out,
    output logic         done,
    output logic         busy
);

`ifdef INV_MIX_ONE_CYCLE_EN

    logic [127:0] mixed_all;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_col (
            .col_in  (state[127-32*c -: 32]),
            .col_out (mixed_all[127-32*c -: 32])
        );
    end

    // A request seen while the done pulse is showing waits one cycle, so a held
    // enable yields a result every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_out <= 128'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable && !done) begin
                state_out <= mixed_all;
                done      <= 1'b1;
            end
        end
    end

    assign busy = 1'b0;

`else

    fsm_state_t   fsm_state, next_state;
    logic [127:0] captured;
    logic [95:0]  res_buf;
    logic [1:0]   col_idx;
    logic [31:0]  col_sel;
    logic [31:0]  col_mixed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_state <= IDLE;
        else        fsm_state <= next_state;
    end

    always_comb begin
        next_state = fsm_state;
        case (fsm_state)
            IDLE: if (enable) next_state = RUN;
            RUN:  if (col_idx == 2'd3) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        col_sel = captured[127:96];
        case (col_idx)
            2'd0: col_sel = captured[127:96];
            2'd1: col_sel = captured[95:64];
            2'd2: col_sel = captured[63:32];
            2'd3: col_sel = captured[31:0];
            default: col_sel = captured[127:96];
        endcase
    end

    inv_mix_column u_col (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

    // Columns 0..2 park in res_buf; column 3 goes straight into state_out
    // together with the buffer so the output changes in a single edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured  <= 128'd0;
            res_buf   <= 96'd0;
            col_idx   <= 2'd0;
            state_out <= 128'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (enable) begin
                        captured <= state;
                        col_idx  <= 2'd0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    col_idx <= col_idx + 2'd1;
                    case (col_idx)
                        2'd0: res_buf[95:64] <= col_mixed;
                        2'd1: res_buf[63:32] <= col_mixed;
                        2'd2: res_buf[31:0]  <= col_mixed;
                        2'd3: begin
                            state_out <= {res_buf, col_mixed};
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns (column-serial build) against a
// polynomial-arithmetic reference model of MixColumns / InvMixColumns.
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] state;
    logic [127:0] state_out;
    logic         done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_mix_columns dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .state     (state),
        .state_out (state_out),
        .done      (done),
        .busy      (busy)
    );

    // Carry-less product followed by long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul_ref(input int a, input int b);
        int prod;
        prod = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) prod = prod ^ (a << i);
        for (int bit_pos = 14; bit_pos >= 8; bit_pos--)
            if (((prod >> bit_pos) & 1) != 0) prod = prod ^ ('h11b << (bit_pos - 8));
        return 8'(prod);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int c, input int r);
        return s[127-32*c-8*r -: 8];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inverse);
        logic [127:0] o;
        int base [4];
        int acc;
        if (inverse) base = '{14, 11, 13, 9};
        else         base = '{2, 3, 1, 1};
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ int'(gf_mul_ref(base[(j - r + 4) % 4], int'(get_byte(s, c, j))));
                o[127-32*c-8*r -: 8] = 8'(acc);
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full operation: enable for the accept edge only, then wait for done.
    task automatic apply_stimulus(input logic [127:0] s, output logic [127:0] res,
                                  output int lat);
        @(negedge clk);
        state  = s;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        state  = rand128();
        lat    = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        res = state_out;
    endtask

    logic [127:0] res, exp_val, s, got;
    logic [127:0] exp_q[$];
    int lat, pulses, cyc, last;

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        state  = '0;
        #1;
        check_output("reset_state_out", state_out, 128'd0);
        check_output("reset_done_busy", {126'd0, done, busy}, 128'd0);

        @(negedge clk);
        reset = 1'b1;

        $display("[TB] FIPS-197 round vector");
        @(negedge clk);
        state  = 128'h046681e5e0cb199a48f8d37a2806264c;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        state  = rand128();
        check_output("fips_busy_e0", {126'd0, busy, done}, 128'd2);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output($sformatf("fips_busy_e%0d", i), {126'd0, busy, done}, 128'd2);
        end
        @(posedge clk);
        @(negedge clk);
        check_output("fips_done_e4", {126'd0, busy, done}, 128'd1);
        check_output("fips_result", state_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        @(posedge clk);
        @(negedge clk);
        check_output("fips_done_single", {127'd0, done}, 128'd0);

        $display("[TB] column vectors");
        apply_stimulus(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, res, lat);
        check_output("column_vectors", res, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        check_output("column_latency", 128'(lat), 128'd4);

        $display("[TB] input change and ignored enable");
        @(negedge clk);
        s       = rand128();
        exp_val = mix_ref(s, 1'b1);
        state   = s;
        enable  = 1'b1;
        @(posedge clk);
        pulses = 0;
        got    = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                got = state_out;
            end
            if (i <= 3) begin
                state  = rand128();
                enable = 1'b1;
            end else begin
                enable = 1'b0;
            end
            @(posedge clk);
        end
        check_output("hold_result", got, exp_val);
        check_output("hold_one_pulse", 128'(pulses), 128'd1);

        $display("[TB] round trip x1000");
        for (int n = 0; n < 1000; n++) begin
            s = rand128();
            apply_stimulus(mix_ref(s, 1'b0), res, lat);
            check_output($sformatf("round_trip_%0d", n), res, s);
            if (lat != 4)
                check_output($sformatf("round_trip_lat_%0d", n), 128'(lat), 128'd4);
        end

        $display("[TB] back-to-back");
        @(negedge clk);
        s = rand128();
        state = s;
        exp_q.push_back(mix_ref(s, 1'b1));
        enable = 1'b1;
        cyc = 0;
        last = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) begin
                pulses++;
                exp_val = '0;
                if (exp_q.size() > 0) exp_val = exp_q.pop_front();
                check_output($sformatf("b2b_result_%0d", pulses), state_out, exp_val);
                check_output($sformatf("b2b_spacing_%0d", pulses), 128'(cyc - last), 128'd5);
                last = cyc;
                s = rand128();
                state = s;
                exp_q.push_back(mix_ref(s, 1'b1));
            end
        end
        check_output("b2b_pulse_count", 128'(pulses), 128'd6);
        enable = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] reset abort");
        @(negedge clk);
        state  = rand128();
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("abort_state_out", state_out, 128'd0);
        check_output("abort_done_busy", {126'd0, done, busy}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        s       = rand128();
        exp_val = mix_ref(s, 1'b1);
        reset   = 1'b1;
        state   = s;
        enable  = 1'b1;
        pulses  = 0;
        lat     = -1;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            enable = 1'b0;
            if (done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check_output("abort_then_latency", 128'(lat), 128'd4);
        check_output("abort_then_pulses", 128'(pulses), 128'd1);
        check_output("abort_then_result", state_out, exp_val);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
